// File: rtl/interp_pkg.sv
// Shared types and default widths for the pilot interpolation sequencer.
package interp_pkg;

    localparam int IN_WIDTH_DEF  = 17;
    localparam int OUT_WIDTH_DEF = 19;
    localparam int IDX_WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_B,
        ST_EMIT_P,
        ST_EMIT_I1,
        ST_EMIT_I2,
        ST_EMIT_TAIL
    } state_t;

    // Operand pairings for the shared adder (A + B):
    // P = 2Ea+Ea, I1 = 2Ea+Eb, I2 = 2Eb+Ea, TAIL = 2Eb+Eb
    typedef enum logic [1:0] {
        SEL_P,
        SEL_I1,
        SEL_I2,
        SEL_TAIL
    } sel_t;

endpackage

// File: rtl/interp_seq_if.sv
// Pilot-in / estimate-out handshake bundle for interp_seq.
interface interp_seq_if
    import interp_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
);
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_last;
    logic                        in_ready;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [IDX_WIDTH-1:0]        out_idx;
    logic                        out_last;
    logic                        out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/interp_opnd_mux.sv
// Maps an operand-select code to the two sign-extended adder operands.
module interp_opnd_mux
    import interp_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  sel_t                        sel,
    input  logic signed [IN_WIDTH-1:0]  ea,
    input  logic signed [IN_WIDTH-1:0]  eb,
    output logic signed [OUT_WIDTH-1:0] opnd_a,
    output logic signed [OUT_WIDTH-1:0] opnd_b
);
    logic signed [OUT_WIDTH-1:0] ea_ext;
    logic signed [OUT_WIDTH-1:0] eb_ext;
    logic signed [OUT_WIDTH-1:0] ea_x2;
    logic signed [OUT_WIDTH-1:0] eb_x2;

    assign ea_ext = {{(OUT_WIDTH-IN_WIDTH){ea[IN_WIDTH-1]}}, ea};
    assign eb_ext = {{(OUT_WIDTH-IN_WIDTH){eb[IN_WIDTH-1]}}, eb};
    assign ea_x2  = {ea_ext[OUT_WIDTH-2:0], 1'b0};
    assign eb_x2  = {eb_ext[OUT_WIDTH-2:0], 1'b0};

    always_comb begin
        opnd_a = ea_x2;
        opnd_b = ea_ext;
        case (sel)
            SEL_P:    begin opnd_a = ea_x2; opnd_b = ea_ext; end
            SEL_I1:   begin opnd_a = ea_x2; opnd_b = eb_ext; end
            SEL_I2:   begin opnd_a = eb_x2; opnd_b = ea_ext; end
            SEL_TAIL: begin opnd_a = eb_x2; opnd_b = eb_ext; end
            default:  begin opnd_a = ea_x2; opnd_b = ea_ext; end
        endcase
    end
endmodule

// File: rtl/interp_seq.sv
// Expands a pilot estimate stream into 3x-scaled per-subcarrier estimates:
// each pilot gap yields the pilot value and two linear interpolants.
module interp_seq
    import interp_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    interp_seq_if.slave bus
);
    state_t                      state_reg, state_next;
    logic signed [IN_WIDTH-1:0]  ea_reg, eb_reg, ea_opnd;
    logic                        last_reg;
    logic signed [OUT_WIDTH-1:0] data_reg, opnd_a, opnd_b, sum;
    logic [IDX_WIDTH-1:0]        idx_reg;
    sel_t                        sel;
    logic                        in_ready, out_valid, in_fire, out_fire;
    logic                        load_data, cap_ea, cap_eb, shift_ea, idx_inc, idx_clr;

    assign in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_WAIT_B);
    assign out_valid = (state_reg == ST_EMIT_P)  || (state_reg == ST_EMIT_I1) ||
                       (state_reg == ST_EMIT_I2) || (state_reg == ST_EMIT_TAIL);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    // A single-pilot symbol must produce 3*Ea in the same cycle Ea is captured.
    assign ea_opnd = (state_reg == ST_IDLE) ? bus.in_data : ea_reg;

    interp_opnd_mux #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_opnd_mux (
        .sel   (sel),
        .ea    (ea_opnd),
        .eb    (eb_reg),
        .opnd_a(opnd_a),
        .opnd_b(opnd_b)
    );

    assign sum = opnd_a + opnd_b;

    always_comb begin
        state_next = state_reg;
        sel        = SEL_P;
        load_data  = 1'b0;
        cap_ea     = 1'b0;
        cap_eb     = 1'b0;
        shift_ea   = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        case (state_reg)
            ST_IDLE: if (in_fire) begin
                cap_ea = 1'b1;
                if (bus.in_last) begin
                    load_data  = 1'b1;
                    state_next = ST_EMIT_TAIL;
                end else begin
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: if (in_fire) begin
                cap_eb     = 1'b1;
                load_data  = 1'b1;
                state_next = ST_EMIT_P;
            end
            ST_EMIT_P: if (out_fire) begin
                sel        = SEL_I1;
                load_data  = 1'b1;
                idx_inc    = 1'b1;
                state_next = ST_EMIT_I1;
            end
            ST_EMIT_I1: if (out_fire) begin
                sel        = SEL_I2;
                load_data  = 1'b1;
                idx_inc    = 1'b1;
                state_next = ST_EMIT_I2;
            end
            ST_EMIT_I2: if (out_fire) begin
                shift_ea = 1'b1;
                idx_inc  = 1'b1;
                if (last_reg) begin
                    sel        = SEL_TAIL;
                    load_data  = 1'b1;
                    state_next = ST_EMIT_TAIL;
                end else begin
                    state_next = ST_WAIT_B;
                end
            end
            ST_EMIT_TAIL: if (out_fire) begin
                idx_clr    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ea_reg    <= '0;
            eb_reg    <= '0;
            last_reg  <= 1'b0;
            data_reg  <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (cap_ea) begin
                ea_reg <= bus.in_data;
            end else if (shift_ea) begin
                ea_reg <= eb_reg;
            end
            if (cap_eb) begin
                eb_reg   <= bus.in_data;
                last_reg <= bus.in_last;
            end
            if (load_data) begin
                data_reg <= sum;
            end
            if (idx_clr) begin
                idx_reg <= '0;
            end else if (idx_inc) begin
                idx_reg <= idx_reg + IDX_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_reg;
    assign bus.out_idx   = idx_reg;
    assign bus.out_last  = (state_reg == ST_EMIT_TAIL);
endmodule
